vga_frame_scanner: RTL
======================

Name: vga_frame_scanner

Overview:
- Pipelined, parametrised pixel source for the VGA output path.
- Turns the timing generator's draw-enable and scanline coordinates into 8-bit RGB outputs. It reads an external synchronous frame memory, or generates a built-in test pattern.
- Supports configurable stored colour depth and integer pixel upscaling. The pattern mode is latched per frame.
- Sits between the VGA timing generator and the DAC/output registers.

Parameters:
p_H_VISIBLE_AREA, 640, visible pixels per line
p_V_VISIBLE_AREA, 480, visible lines per frame
p_COLOR_BITS, 8, stored bits per channel (1..8)
p_SCALE_SHIFT, 0, log2 of upscale factor per axis (0..3); image is (H>>s) x (V>>s)
p_CHECKER_SHIFT, 4, log2 of checkerboard cell size in screen pixels

Ports:
i_CLK  in  1  pixel clock
i_RESET  in  1  synchronous, active-high reset
i_DRAW_ENABLE  in  1  current pixel is in visible area
i_SCANLINE_X  in  $clog2(p_H_VISIBLE_AREA)  current pixel column
i_SCANLINE_Y  in  $clog2(p_V_VISIBLE_AREA)  current pixel row
i_MODE  in  2  requested mode: 0 image, 1 colour bars, 2 solid, 3 checkerboard
i_SOLID_COLOR  in  24  {R,G,B} 8 bits each, used in mode 2
o_MEM_ADDR  out  $clog2(IMG_W*IMG_H)  frame memory word address (IMG_W=H>>s, IMG_H=V>>s)
o_MEM_READ  out  1  read strobe for o_MEM_ADDR
i_MEM_DATA  in  3*p_COLOR_BITS  {R,G,B} word; valid one cycle after o_MEM_ADDR/o_MEM_READ
o_VGA_RED  out  8  red
o_VGA_GREEN  out  8  green
o_VGA_BLUE  out  8  blue
o_PIXEL_VALID  out  1  outputs correspond to a visible pixel
o_FRAME_COUNT  out  16  completed-frame counter

Behaviour:
- Reset (clock edge with i_RESET=1):
  - o_MEM_ADDR=0, o_MEM_READ=0.
  - RGB=0, o_PIXEL_VALID=0.
  - o_FRAME_COUNT=0, active mode=0, all pipeline stages cleared.
  - Reset mid-frame discards in-flight pixels; the first non-blank output appears 2 cycles after the first post-reset visible input.
- Pipeline, input sampled at edge E:
  - Stage 1 at edge E: registers o_MEM_ADDR = (Y>>s)*IMG_W + (X>>s), o_MEM_READ, and delayed X/Y/valid/mode.
  - Stage 2 at edge E+1: registers RGB and o_PIXEL_VALID.
  - Fixed latency 2 cycles in every mode, with no bubbles. A new pixel is accepted every cycle.
- Pixel validity: a pixel is visible iff i_DRAW_ENABLE=1, X<H and Y<V.
  - Non-visible pixel: o_MEM_READ=0, o_MEM_ADDR holds its previous value, and 2 cycles later RGB=0 and o_PIXEL_VALID=0.
- o_MEM_READ=1 only for visible pixels when the active mode is 0.
- Mode latch: the active mode loads from i_MODE only when a visible pixel with X=0, Y=0 is sampled. That pixel already uses the new mode. A mid-frame i_MODE change has no effect until the next frame.
- Mode 0: RGB is i_MEM_DATA expanded per channel by MSB-first bit replication to 8 bits.
  - CB=8: identity.
  - CB=4: 0xA -> 0xAA.
  - CB=5: 10110 -> 10110101.
  - CB=1: 1 -> 0xFF.
- Mode 1: 8 vertical bars, index = floor(X*8/H), in order white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is 0xFF or 0x00 (e.g. yellow = FF,FF,00).
- Mode 2: RGB = i_SOLID_COLOR, sampled with the pixel at stage 1.
- Mode 3: ((X>>p_CHECKER_SHIFT) XOR (Y>>p_CHECKER_SHIFT)) bit0 = 0 -> white, 1 -> black.
- Frame count: o_FRAME_COUNT increments by 1 at the edge sampling a visible pixel with X=H-1, Y=V-1.
  - Wraps 0xFFFF -> 0x0000.
- Reset has priority over all other events in the same cycle.

Test Plan:
- Reset held 3 cycles during visible pixels -> all outputs 0; after release, pixel (0,0) in mode 0 gives o_PIXEL_VALID=1 exactly 2 cycles later.
- Mode 0, CB=8, s=0, memory model returns addr-derived data, sweep full frame -> o_MEM_ADDR = Y*640+X; RGB matches the word at latency 2; o_FRAME_COUNT goes 0->1 after (639,479).
- Mode 0, s=1, CB=4 -> pixels (0,0),(1,0),(0,1),(1,1) all use address 0; (2,2) uses address 321; data 0xA5F -> RGB AA,55,FF.
- Mode 1, set mid-frame at (100,50) -> unchanged until next frame's (0,0); then X=0 gives FF,FF,FF, X=80 gives FF,FF,00, X=639 gives 00,00,00; o_MEM_READ stays 0.
- Mode 3, shift 4 -> (15,0) white, (16,0) black, (16,16) white; i_DRAW_ENABLE=0 or X=700 -> RGB 0, o_PIXEL_VALID 0.
- o_FRAME_COUNT preloaded near wrap via 65536 simulated frame ends (fast short-frame config H=8, V=4) -> 0xFFFF then 0x0000.

Source files
------------

// File: rtl/vga_frame_scanner.sv
// Two-stage pixel source: maps visible scanline coordinates to RGB from frame memory
// or from a built-in test pattern, with per-frame mode latching and a frame counter.
module vga_frame_scanner #(
  parameter int p_H_VISIBLE_AREA = 640,
  parameter int p_V_VISIBLE_AREA = 480,
  parameter int p_COLOR_BITS     = 8,
  parameter int p_SCALE_SHIFT    = 0,
  parameter int p_CHECKER_SHIFT  = 4
) (
  input  logic                                     i_CLK,
  input  logic                                     i_RESET,
  input  logic                                     i_DRAW_ENABLE,
  input  logic [$clog2(p_H_VISIBLE_AREA)-1:0]      i_SCANLINE_X,
  input  logic [$clog2(p_V_VISIBLE_AREA)-1:0]      i_SCANLINE_Y,
  input  logic [1:0]                               i_MODE,
  input  logic [23:0]                              i_SOLID_COLOR,
  output logic [$clog2((p_H_VISIBLE_AREA >> p_SCALE_SHIFT) *
                       (p_V_VISIBLE_AREA >> p_SCALE_SHIFT))-1:0] o_MEM_ADDR,
  output logic                                     o_MEM_READ,
  input  logic [3*p_COLOR_BITS-1:0]                i_MEM_DATA,
  output logic [7:0]                               o_VGA_RED,
  output logic [7:0]                               o_VGA_GREEN,
  output logic [7:0]                               o_VGA_BLUE,
  output logic                                     o_PIXEL_VALID,
  output logic [15:0]                              o_FRAME_COUNT
);

  localparam int X_W    = $clog2(p_H_VISIBLE_AREA);
  localparam int Y_W    = $clog2(p_V_VISIBLE_AREA);
  localparam int IMG_W  = p_H_VISIBLE_AREA >> p_SCALE_SHIFT;
  localparam int IMG_H  = p_V_VISIBLE_AREA >> p_SCALE_SHIFT;
  localparam int ADDR_W = $clog2(IMG_W * IMG_H);
  localparam int CB     = p_COLOR_BITS;

  typedef enum logic [1:0] {
    MODE_IMAGE   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_SOLID   = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  // MSB-first bit replication widens a stored channel to the full 8-bit DAC range.
  function automatic logic [7:0] expand_channel(input logic [CB-1:0] c);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[7-k] = c[CB-1-(k % CB)];
    end
    return r;
  endfunction

  mode_e              active_mode_q, active_mode_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_read_q, mem_read_d;
  logic               s1_valid_q, s1_valid_d;
  logic [X_W-1:0]     s1_x_q, s1_x_d;
  logic [Y_W-1:0]     s1_y_q, s1_y_d;
  mode_e              s1_mode_q, s1_mode_d;
  logic [23:0]        s1_solid_q, s1_solid_d;
  logic [23:0]        rgb_q, rgb_d;
  logic               pixel_valid_q, pixel_valid_d;

  logic               pix_visible;
  logic               pix_origin;
  logic               pix_last;
  mode_e              pix_mode;
  logic [ADDR_W-1:0]  pix_addr;
  logic [2:0]         bar_idx;
  logic               checker_black;

  always_comb begin
    pix_visible = i_DRAW_ENABLE &&
                  (32'(i_SCANLINE_X) < 32'(p_H_VISIBLE_AREA)) &&
                  (32'(i_SCANLINE_Y) < 32'(p_V_VISIBLE_AREA));
    pix_origin  = pix_visible && (i_SCANLINE_X == '0) && (i_SCANLINE_Y == '0);
    pix_last    = pix_visible &&
                  (32'(i_SCANLINE_X) == 32'(p_H_VISIBLE_AREA - 1)) &&
                  (32'(i_SCANLINE_Y) == 32'(p_V_VISIBLE_AREA - 1));
    // The first pixel of a frame already renders with the newly requested mode.
    pix_mode    = pix_origin ? mode_e'(i_MODE) : active_mode_q;
    pix_addr    = ADDR_W'(i_SCANLINE_Y >> p_SCALE_SHIFT) * ADDR_W'(IMG_W) +
                  ADDR_W'(i_SCANLINE_X >> p_SCALE_SHIFT);
  end

  always_comb begin
    active_mode_d = active_mode_q;
    frame_count_d = frame_count_q;
    mem_addr_d    = mem_addr_q;
    mem_read_d    = 1'b0;
    s1_valid_d    = pix_visible;
    s1_x_d        = i_SCANLINE_X;
    s1_y_d        = i_SCANLINE_Y;
    s1_mode_d     = pix_mode;
    s1_solid_d    = i_SOLID_COLOR;

    if (pix_origin) begin
      active_mode_d = mode_e'(i_MODE);
    end
    if (pix_last) begin
      frame_count_d = frame_count_q + 16'd1;
    end
    if (pix_visible) begin
      mem_addr_d = pix_addr;
      mem_read_d = (pix_mode == MODE_IMAGE);
    end
  end

  // Bar order white..black is the bit-inverted index: R=~b1, G=~b2, B=~b0.
  always_comb begin
    bar_idx       = 3'((32'(s1_x_q) * 32'd8) / 32'(p_H_VISIBLE_AREA));
    checker_black = |(((32'(s1_x_q) ^ 32'(s1_y_q)) >> p_CHECKER_SHIFT) & 32'd1);

    rgb_d         = '0;
    pixel_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      case (s1_mode_q)
        MODE_IMAGE: begin
          rgb_d = {expand_channel(i_MEM_DATA[3*CB-1:2*CB]),
                   expand_channel(i_MEM_DATA[2*CB-1:CB]),
                   expand_channel(i_MEM_DATA[CB-1:0])};
        end
        MODE_BARS: begin
          rgb_d = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
        end
        MODE_SOLID: begin
          rgb_d = s1_solid_q;
        end
        MODE_CHECKER: begin
          rgb_d = checker_black ? 24'h000000 : 24'hFFFFFF;
        end
        default: begin
          rgb_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      active_mode_q <= MODE_IMAGE;
      frame_count_q <= '0;
      mem_addr_q    <= '0;
      mem_read_q    <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
      s1_mode_q     <= MODE_IMAGE;
      s1_solid_q    <= '0;
      rgb_q         <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      active_mode_q <= active_mode_d;
      frame_count_q <= frame_count_d;
      mem_addr_q    <= mem_addr_d;
      mem_read_q    <= mem_read_d;
      s1_valid_q    <= s1_valid_d;
      s1_x_q        <= s1_x_d;
      s1_y_q        <= s1_y_d;
      s1_mode_q     <= s1_mode_d;
      s1_solid_q    <= s1_solid_d;
      rgb_q         <= rgb_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign o_MEM_ADDR    = mem_addr_q;
  assign o_MEM_READ    = mem_read_q;
  assign o_VGA_RED     = rgb_q[23:16];
  assign o_VGA_GREEN   = rgb_q[15:8];
  assign o_VGA_BLUE    = rgb_q[7:0];
  assign o_PIXEL_VALID = pixel_valid_q;
  assign o_FRAME_COUNT = frame_count_q;

endmodule
